// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types and constants for the 4x4 keypad scanner:
//                scanner FSM state encoding, idle row/column pattern, the
//                one-hot-low row drive codes and small decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2
    } kp_state_t;

    // All-high pattern: no row driven / no column pulled low.
    localparam logic [3:0] ROW_IDLE = 4'hF;

    localparam logic [3:0] ROW_0 = 4'b1110;
    localparam logic [3:0] ROW_1 = 4'b1101;
    localparam logic [3:0] ROW_2 = 4'b1011;
    localparam logic [3:0] ROW_3 = 4'b0111;

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        logic [3:0] drv;
        case (idx)
            2'd0:    drv = ROW_0;
            2'd1:    drv = ROW_1;
            2'd2:    drv = ROW_2;
            default: drv = ROW_3;
        endcase
        return drv;
    endfunction

    // Index of the lowest column pulled low; lowest index wins on multi-press.
    function automatic logic [1:0] low_col(input logic [3:0] pat);
        logic [1:0] idx;
        if (!pat[0])      idx = 2'd0;
        else if (!pat[1]) idx = 2'd1;
        else if (!pat[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_debounce
//  Description : Stability counter shared by press and release qualification.
//                Counts consecutive cycles with i_stable high; any unstable
//                cycle or i_load clears it. o_done flags the cycle in which
//                the DEBOUNCE_CYCLES-th consecutive stable cycle is seen.
//  Ports       : clk, reset   - clock, synchronous active-high reset
//                i_load       - clear the count (new qualification window)
//                i_stable     - input matches the reference this cycle
//                o_done       - stable run complete (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_stable,
    output logic o_done
);

    localparam int             c_CW   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DEBOUNCE_CYCLES - 1);

    logic [c_CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_load || !i_stable) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_done = i_stable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 hex keypad scanner. Drives one row low at a time,
//                samples the columns, debounces press and release, decodes
//                the key (row*4 + col) and packs two successive keys into a
//                byte (first key -> upper nibble, second -> lower nibble).
//  Ports       : clk, reset  - clock, synchronous active-high reset
//                cols[3:0]   - keypad columns, active-low
//                rows[3:0]   - row drive, active-low, exactly one bit low
//                key_valid   - 1-cycle pulse on each accepted key
//                key_code    - last accepted key code
//                data_out    - assembled byte
//                data_valid  - 1-cycle pulse when the lower nibble lands
//                nibble_sel  - 0: next key -> [7:4], 1: next key -> [3:0]
//  Options     : KEYPAD_SYNC_EN - adds a 2-flop column synchronizer
//                (reset to 4'hF), +2 cycles of press latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       nibble_sel
);

    localparam int              c_SW        = $clog2(SCAN_DIV);
    localparam logic [c_SW-1:0] c_SLOT_LAST = c_SW'(SCAN_DIV - 1);

    logic [3:0] w_cols;

`ifdef KEYPAD_SYNC_EN
    logic [3:0] r_cols_meta;
    logic [3:0] r_cols_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cols_meta <= ROW_IDLE;
            r_cols_sync <= ROW_IDLE;
        end else begin
            r_cols_meta <= cols;
            r_cols_sync <= r_cols_meta;
        end
    end

    assign w_cols = r_cols_sync;
`else
    assign w_cols = cols;
`endif

    kp_state_t       r_state;
    logic [1:0]      r_row_idx;
    logic [3:0]      r_rows;
    logic [c_SW-1:0] r_slot;
    logic [3:0]      r_pattern;

    logic       w_stable;
    logic       w_capture;
    logic       w_db_done;
    logic [3:0] w_code;

    // Press: columns must keep the captured pattern. Release: all columns high.
    assign w_stable  = ((r_state == ST_DEBOUNCE) && (w_cols == r_pattern)) ||
                       ((r_state == ST_HOLD)     && (w_cols == ROW_IDLE));
    assign w_capture = (r_state == ST_SCAN) && (r_slot == c_SLOT_LAST) &&
                       (w_cols != ROW_IDLE);
    assign w_code    = {r_row_idx, low_col(r_pattern)};

    // One counter serves both windows; it is cleared on every window start.
    keypad_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_capture || w_db_done),
        .i_stable(w_stable),
        .o_done  (w_db_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_SCAN;
            r_row_idx  <= 2'd0;
            r_rows     <= ROW_0;
            r_slot     <= '0;
            r_pattern  <= ROW_IDLE;
            key_valid  <= 1'b0;
            key_code   <= 4'h0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            nibble_sel <= 1'b0;
        end else begin
            key_valid  <= 1'b0;
            data_valid <= 1'b0;
            case (r_state)
                ST_SCAN: begin
                    if (r_slot == c_SLOT_LAST) begin
                        r_slot <= '0;
                        if (w_cols != ROW_IDLE) begin
                            // Stay on this row so the key remains visible.
                            r_pattern <= w_cols;
                            r_state   <= ST_DEBOUNCE;
                        end else begin
                            r_row_idx <= r_row_idx + 2'd1;
                            r_rows    <= row_drive(r_row_idx + 2'd1);
                        end
                    end else begin
                        r_slot <= r_slot + 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (w_cols != r_pattern) begin
                        r_state <= ST_SCAN;
                        r_slot  <= '0;
                    end else if (w_db_done) begin
                        key_valid <= 1'b1;
                        key_code  <= w_code;
                        r_state   <= ST_HOLD;
                        if (!nibble_sel) begin
                            data_out[7:4] <= w_code;
                            nibble_sel    <= 1'b1;
                        end else begin
                            data_out[3:0] <= w_code;
                            nibble_sel    <= 1'b0;
                            data_valid    <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_db_done) begin
                        r_state   <= ST_SCAN;
                        r_slot    <= '0;
                        r_row_idx <= r_row_idx + 2'd1;
                        r_rows    <= row_drive(r_row_idx + 2'd1);
                    end
                end
                default: begin
                    r_state <= ST_SCAN;
                    r_slot  <= '0;
                end
            endcase
        end
    end

    assign rows = r_rows;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Self-checking bench for keypad_scanner (default build,
//                column synchronizer not compiled in). A behavioural keypad
//                pulls the pressed key's columns low while its row is driven.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] cols;
    logic [3:0] rows;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] data_out;
    logic       data_valid;
    logic       nibble_sel;

    logic       press_en   = 1'b0;
    logic [1:0] press_row  = 2'd0;
    logic [3:0] press_mask = 4'h0;   // 1 = column pulled low

    int n_checks = 0;
    int n_fail   = 0;
    int kv_count = 0;

    always #5 clk = ~clk;

    assign cols = (press_en && !rows[press_row]) ? ~press_mask : 4'hF;

    always @(negedge clk) if (key_valid) kv_count++;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cols      (cols),
        .rows      (rows),
        .key_valid (key_valid),
        .key_code  (key_code),
        .data_out  (data_out),
        .data_valid(data_valid),
        .nibble_sel(nibble_sel)
    );

    typedef struct {
        logic [1:0] row;
        logic [3:0] mask;
        int         hold;
        logic [3:0] exp_code;
        logic [7:0] exp_data;
        logic       exp_nsel;
        logic       exp_dv;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Leaves the bench at the negedge just after the last reset edge.
    task automatic do_reset();
        reset    = 1'b1;
        press_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_rows[5];
        logic       early;
        logic       found;
        int         kv0;

        exp_rows[0] = 4'b1110;
        exp_rows[1] = 4'b1101;
        exp_rows[2] = 4'b1011;
        exp_rows[3] = 4'b0111;
        exp_rows[4] = 4'b1110;

        // row, low-column mask, extra hold cycles, expected code/data/nsel/dv
        vecs[0] = '{2'd2, 4'b0010,   0, 4'h9, 8'h90, 1'b1, 1'b0};
        vecs[1] = '{2'd0, 4'b1000,   0, 4'h3, 8'h93, 1'b0, 1'b1};
        // cols = 0101: columns 1 and 3 low, column 1 wins -> 1*4+1
        vecs[2] = '{2'd1, 4'b1010, 100, 4'h5, 8'h53, 1'b1, 1'b0};
        vecs[3] = '{2'd3, 4'b0001,   0, 4'hC, 8'h5C, 1'b0, 1'b1};
        vecs[4] = '{2'd3, 4'b1000,   0, 4'hF, 8'hFC, 1'b1, 1'b0};

        // ---- reset state and idle row rotation ----
        do_reset();
        check("reset key_valid",  {7'd0, key_valid},  8'h00);
        check("reset key_code",   {4'd0, key_code},   8'h00);
        check("reset data_out",   data_out,           8'h00);
        check("reset nibble_sel", {7'd0, nibble_sel}, 8'h00);
        check("reset data_valid", {7'd0, data_valid}, 8'h00);
        check("idle rows 0", {4'd0, rows}, {4'd0, exp_rows[0]});
        for (int k = 1; k < 5; k++) begin
            repeat (SCAN_DIV) @(negedge clk);
            check($sformatf("idle rows %0d", k), {4'd0, rows}, {4'd0, exp_rows[k]});
        end
        check("idle no key_valid", kv_count[7:0], 8'h00);

        // ---- bounce 5 cycles into debounce, then stable accept ----
        // Row 0 sampled at edge 4; bounce seen at edge 10 -> rescan of row 0,
        // resample at edge 14, accept at edge 22.
        do_reset();
        press_row  = 2'd0;
        press_mask = 4'b0100;
        press_en   = 1'b1;
        early      = 1'b0;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            if (i == 9)  press_en = 1'b0;
            if (i == 10) press_en = 1'b1;
            if (i < 22 && key_valid) early = 1'b1;
        end
        check("bounce no early key_valid", {7'd0, early}, 8'h00);
        check("bounce accept key_valid", {7'd0, key_valid}, 8'h01);
        check("bounce accept key_code", {4'd0, key_code}, 8'h02);
        check("bounce accept data_out", data_out, 8'h20);
        check("bounce accept nibble_sel", {7'd0, nibble_sel}, 8'h01);

        // ---- reset while holding after the first nibble ----
        repeat (3) @(negedge clk);
        reset    = 1'b1;
        press_en = 1'b0;
        @(negedge clk);
        check("hold reset data_out", data_out, 8'h00);
        check("hold reset nibble_sel", {7'd0, nibble_sel}, 8'h00);
        check("hold reset rows", {4'd0, rows}, 8'h0E);
        check("hold reset key_code", {4'd0, key_code}, 8'h00);
        reset = 1'b0;

        // ---- table-driven key sequence ----
        for (int v = 0; v < 5; v++) begin
            kv0        = kv_count;
            press_row  = vecs[v].row;
            press_mask = vecs[v].mask;
            press_en   = 1'b1;
            found      = 1'b0;
            for (int c = 0; c < 64 && !found; c++) begin
                @(negedge clk);
                if (key_valid) found = 1'b1;
            end
            check($sformatf("vec%0d key_valid seen", v), {7'd0, found}, 8'h01);
            check($sformatf("vec%0d key_code", v), {4'd0, key_code}, {4'd0, vecs[v].exp_code});
            check($sformatf("vec%0d data_out", v), data_out, vecs[v].exp_data);
            check($sformatf("vec%0d nibble_sel", v), {7'd0, nibble_sel}, {7'd0, vecs[v].exp_nsel});
            check($sformatf("vec%0d data_valid", v), {7'd0, data_valid}, {7'd0, vecs[v].exp_dv});
            @(negedge clk);
            check($sformatf("vec%0d key_valid pulse end", v), {7'd0, key_valid}, 8'h00);
            check($sformatf("vec%0d data_valid pulse end", v), {7'd0, data_valid}, 8'h00);
            repeat (vecs[v].hold) @(negedge clk);
            press_en = 1'b0;
            repeat (DEBOUNCE_CYCLES + 4) @(negedge clk);
            check($sformatf("vec%0d single accept", v), 8'(kv_count - kv0), 8'h01);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
